// File: rtl/pmem_responder_if.sv
// rtl/pmem_responder_if.sv - cache-to-physical-memory line request/response bundle
interface pmem_responder_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_BITS  = 128
);
  logic [ADDR_WIDTH-1:0] pmem_address;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [LINE_BITS-1:0]  pmem_wdata;
  logic [LINE_BITS-1:0]  pmem_rdata;
  logic                  pmem_resp;
  logic                  pmem_error;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp, pmem_error
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp, pmem_error
  );
endinterface

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - fixed-latency line-granular physical memory below the cache
module pmem_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_BITS  = 128,
  parameter int INDEX_BITS = 6,
  parameter int LATENCY    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  pmem_responder_if.slave  bus
);
  localparam int IDX_HI = 3 + INDEX_BITS;

  typedef enum logic [1:0] {IDLE, BUSY, RESP, TURN} state_t;

  state_t                 state, state_nxt;
  logic [3:0]             cnt, cnt_nxt;
  logic [INDEX_BITS-1:0]  idx_q, idx_in, idx_eff;
  logic                   rd_q, wr_q;
  logic [LINE_BITS-1:0]   wdata_q, rdata_q;
  logic                   accept, abort, rd_eff, load_rdata;
  logic                   unused_addr_bits;

  logic [LINE_BITS-1:0]   store [0:(1<<INDEX_BITS)-1];

  // Offset and high address bits never select a line, so they alias.
  assign unused_addr_bits = ^{bus.pmem_address[ADDR_WIDTH-1:IDX_HI+1], bus.pmem_address[3:0]};
  assign idx_in = bus.pmem_address[IDX_HI:4];

  assign accept = (state == IDLE) & (bus.pmem_read | bus.pmem_write);
  assign abort  = (rd_q & ~bus.pmem_read) | (wr_q & ~bus.pmem_write);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          cnt_nxt   = 4'(LATENCY - 1);
          state_nxt = (LATENCY == 1) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (abort) begin
          cnt_nxt   = 4'd0;
          state_nxt = IDLE;
        end else if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = RESP;
        end else begin
          cnt_nxt   = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = TURN;
      TURN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // On the direct IDLE->RESP path the latched copy is not loaded yet.
  assign idx_eff    = (state == IDLE) ? idx_in : idx_q;
  assign rd_eff     = (state == IDLE) ? (bus.pmem_read & ~bus.pmem_write) : (rd_q & ~wr_q);
  assign load_rdata = (state != RESP) && (state_nxt == RESP) && rd_eff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      idx_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        idx_q   <= idx_in;
        rd_q    <= bus.pmem_read;
        wr_q    <= bus.pmem_write;
        wdata_q <= bus.pmem_wdata;
      end
      if (load_rdata) begin
        rdata_q <= store[idx_eff];
      end
    end
  end

  // Writebacks commit only at the RESP exit edge; a conflicting request never commits.
  always_ff @(posedge clk) begin
    if (state == RESP && wr_q && !rd_q) begin
      store[idx_q] <= wdata_q;
    end
  end

  assign bus.pmem_resp  = (state == RESP);
  assign bus.pmem_error = (state == RESP) & rd_q & wr_q;
  assign bus.pmem_rdata = rdata_q;
endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - bench for pmem_responder
module tb_pmem_responder;
  localparam logic [127:0] L1 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
  localparam logic [127:0] L2 = 128'hA5A5_0000_1111_2222_3333_4444_5555_0202;
  localparam logic [127:0] L3 = 128'h3030_FEDC_BA98_7654_3210_0F0F_F0F0_0303;
  localparam logic [127:0] L4 = 128'h4040_1357_9BDF_2468_ACE0_DEAD_BEEF_0404;
  localparam logic [127:0] L5 = 128'h5050_CAFE_F00D_1234_5678_9ABC_DEF0_0505;
  localparam logic [127:0] L6 = 128'h6060_0BAD_C0DE_7777_8888_9999_AAAA_0606;
  localparam logic [127:0] L7 = 128'h7070_5555_6666_1010_2020_3030_4040_0707;

  typedef struct {
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
    logic         chg;
    logic         exp_err;
    logic         chk_rd;
    logic [127:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic         exp_err;
    logic         chk_rd;
    logic [127:0] exp_rdata;
    int           exp_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t sb[$];
  vec_t tbl[12];

  pmem_responder_if #(.ADDR_WIDTH(16), .LINE_BITS(128)) bus ();

  pmem_responder #(.ADDR_WIDTH(16), .LINE_BITS(128), .INDEX_BITS(6), .LATENCY(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic sb_push(input logic err, input logic chk, input logic [127:0] rdv, input int lat);
    exp_t e;
    e.exp_err = err;
    e.chk_rd = chk;
    e.exp_rdata = rdv;
    e.exp_lat = lat;
    sb.push_back(e);
  endtask

  task automatic sb_check(input int lat);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL sb_empty actual=resp required=none");
    end else begin
      e = sb.pop_front();
      check("latency", 128'(lat), 128'(e.exp_lat));
      check("error", 128'(bus.pmem_error), 128'(e.exp_err));
      if (e.chk_rd) check("rdata", bus.pmem_rdata, e.exp_rdata);
    end
  endtask

  // Counts negedges from the drive cycle until pmem_resp is seen.
  task automatic wait_resp(input logic chg, output int n, output bit got);
    n = 0;
    got = 0;
    while (n <= 20 && !got) begin
      @(negedge clk);
      if (bus.pmem_resp) got = 1;
      else n++;
      if (chg && n == 2) begin
        bus.pmem_address = bus.pmem_address ^ 16'h00F0;
        bus.pmem_wdata   = ~bus.pmem_wdata;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL resp_timeout actual=no_resp required=resp");
      if (sb.size() > 0) void'(sb.pop_front());
    end
  endtask

  task automatic run_req(input vec_t v);
    int n;
    bit got;
    @(posedge clk);
    #1;
    bus.pmem_read    = v.rd;
    bus.pmem_write   = v.wr;
    bus.pmem_address = v.addr;
    bus.pmem_wdata   = v.wdata;
    sb_push(v.exp_err, v.chk_rd, v.exp_rdata, 4);
    wait_resp(v.chg, n, got);
    if (got) sb_check(n);
    @(posedge clk);
    #1;
    bus.pmem_read  = 1'b0;
    bus.pmem_write = 1'b0;
    @(negedge clk);
    check("resp_turn", 128'(bus.pmem_resp), 128'(0));
  endtask

  initial begin
    int n, t1, t2, hits;
    bit got;

    tbl[0]  = '{1'b0, 1'b1, 16'h0010, L1,  1'b0, 1'b0, 1'b1, 128'h0};
    tbl[1]  = '{1'b1, 1'b0, 16'h001A, 128'h0, 1'b0, 1'b0, 1'b1, L1};
    tbl[2]  = '{1'b1, 1'b0, 16'h0410, 128'h0, 1'b0, 1'b0, 1'b1, L1};
    tbl[3]  = '{1'b0, 1'b1, 16'h0020, L2,  1'b0, 1'b0, 1'b1, L1};
    tbl[4]  = '{1'b0, 1'b1, 16'h0030, L3,  1'b0, 1'b0, 1'b1, L1};
    tbl[5]  = '{1'b0, 1'b1, 16'h0040, L4,  1'b0, 1'b0, 1'b1, L1};
    tbl[6]  = '{1'b0, 1'b1, 16'h0050, L5,  1'b0, 1'b0, 1'b1, L1};
    tbl[7]  = '{1'b0, 1'b1, 16'h0060, L6,  1'b0, 1'b0, 1'b1, L1};
    tbl[8]  = '{1'b1, 1'b1, 16'h0040, ~L4, 1'b0, 1'b1, 1'b1, L1};
    tbl[9]  = '{1'b1, 1'b0, 16'h0040, 128'h0, 1'b0, 1'b0, 1'b1, L4};
    tbl[10] = '{1'b0, 1'b1, 16'h0070, L7,  1'b1, 1'b0, 1'b1, L4};
    tbl[11] = '{1'b1, 1'b0, 16'h0070, 128'h0, 1'b0, 1'b0, 1'b1, L7};

    bus.pmem_read    = 1'b0;
    bus.pmem_write   = 1'b0;
    bus.pmem_address = '0;
    bus.pmem_wdata   = '0;
    #1;
    check("rst_resp", 128'(bus.pmem_resp), 128'(0));
    check("rst_error", 128'(bus.pmem_error), 128'(0));
    check("rst_rdata", bus.pmem_rdata, 128'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_req(tbl[i]);

    // Back-to-back reads with pmem_read held across the turnaround.
    @(posedge clk);
    #1;
    bus.pmem_read = 1'b1;
    bus.pmem_address = 16'h0020;
    sb_push(1'b0, 1'b1, L2, 4);
    wait_resp(1'b0, n, got);
    t1 = cyc;
    if (got) sb_check(n);
    @(posedge clk);
    #1 bus.pmem_address = 16'h0030;
    @(negedge clk);
    check("b2b_turn", 128'(bus.pmem_resp), 128'(0));
    sb_push(1'b0, 1'b1, L3, 6);
    wait_resp(1'b0, n, got);
    t2 = cyc;
    if (got) sb_check(t2 - t1);
    @(posedge clk);
    #1 bus.pmem_read = 1'b0;
    @(negedge clk);

    // Write to 0x0050 abandoned after two cycles.
    @(posedge clk);
    #1;
    bus.pmem_write = 1'b1;
    bus.pmem_address = 16'h0050;
    bus.pmem_wdata = ~L5;
    @(posedge clk);
    @(posedge clk);
    #1 bus.pmem_write = 1'b0;
    hits = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.pmem_resp) hits++;
    end
    check("abort_noresp", 128'(hits), 128'(0));
    run_req('{1'b1, 1'b0, 16'h0050, 128'h0, 1'b0, 1'b0, 1'b1, L5});

    // Reset pulse in the middle of a write to 0x0060.
    @(posedge clk);
    #1;
    bus.pmem_write = 1'b1;
    bus.pmem_address = 16'h0060;
    bus.pmem_wdata = ~L6;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    bus.pmem_write = 1'b0;
    #1;
    check("midrst_resp", 128'(bus.pmem_resp), 128'(0));
    check("midrst_error", 128'(bus.pmem_error), 128'(0));
    check("midrst_rdata", bus.pmem_rdata, 128'h0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b1;
    run_req('{1'b1, 1'b0, 16'h0060, 128'h0, 1'b0, 1'b0, 1'b1, L6});

    check("sb_drained", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end
endmodule
